// File: rtl/smult8_pkg.sv
// Shared constants, Booth digit encoding and carry-save helper for the smult8 multiplier.
package smult8_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned OUTWIDTH = 2 * WIDTH;
  localparam int unsigned NUM_PP   = WIDTH / 2;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  typedef logic [OUTWIDTH-1:0] pp_vec_t [NUM_PP];

  typedef struct packed {
    logic [OUTWIDTH-1:0] sum;
    logic [OUTWIDTH-1:0] carry;
  } csa_t;

  // Triplet {b[2i+1], b[2i], b[2i-1]}; 000 and 111 both encode zero.
  function automatic booth_digit_t booth_encode(input logic [2:0] t);
    booth_digit_t d;
    d.neg = t[2] & ~(t[1] & t[0]);
    d.one = t[1] ^ t[0];
    d.two = (t == 3'b011) | (t == 3'b100);
    return d;
  endfunction

  function automatic csa_t csa(input logic [OUTWIDTH-1:0] a,
                               input logic [OUTWIDTH-1:0] b,
                               input logic [OUTWIDTH-1:0] c);
    csa_t r;
    r.sum   = a ^ b ^ c;
    r.carry = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth partial product, sign-extended to OUTWIDTH, plus its negate-carry bit.
module booth_pp_gen
  import smult8_pkg::*;
(
  input  logic [WIDTH-1:0]    mcand_i,
  input  logic [2:0]          triplet_i,
  output logic [OUTWIDTH-1:0] pp_o,
  output logic                neg_o
);

  booth_digit_t     dig;
  logic [WIDTH:0]   mag;
  logic [WIDTH:0]   sel;

  always_comb begin
    dig = booth_encode(triplet_i);
    mag = '0;
    if (dig.two) begin
      mag = {mcand_i, 1'b0};
    end else if (dig.one) begin
      mag = {mcand_i[WIDTH-1], mcand_i};
    end
    // One's complement here; the +1 travels separately as neg_o.
    sel   = dig.neg ? ~mag : mag;
    pp_o  = {{(OUTWIDTH - WIDTH - 1){sel[WIDTH]}}, sel};
    neg_o = dig.neg;
  end

endmodule

// File: rtl/smult8_core.sv
// Signed 8x8 radix-4 Booth multiplier with CSA reduction and registered 16-bit product.
// Define INPUT_REG_EN to register IN1/IN2 ahead of the Booth stage (latency 2).
module smult8_core
  import smult8_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    IN1,
  input  logic [WIDTH-1:0]    IN2,
  output logic [OUTWIDTH-1:0] P
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

`ifdef INPUT_REG_EN
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in1_q <= '0;
      in2_q <= '0;
    end else begin
      in1_q <= IN1;
      in2_q <= IN2;
    end
  end

  assign mcand  = in1_q;
  assign mplier = in2_q;
`else
  assign mcand  = IN1;
  assign mplier = IN2;
`endif

  logic [WIDTH:0]      mplier_x;
  pp_vec_t             pp;
  logic [NUM_PP-1:0]   neg;

  assign mplier_x = {mplier, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen u_pp (
      .mcand_i  (mcand),
      .triplet_i(mplier_x[2*i+2 -: 3]),
      .pp_o     (pp[i]),
      .neg_o    (neg[i])
    );
  end

  logic [OUTWIDTH-1:0] opnd [NUM_PP+1];
  logic [OUTWIDTH-1:0] negv;
  csa_t                l1, l2, l3;
  logic [OUTWIDTH-1:0] prod_d;

  always_comb begin
    negv = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      opnd[i]     = pp[i] << (2 * i);
      negv[2 * i] = neg[i];
    end
    // Negate-carries sit at distinct even bit positions, so they share one row.
    opnd[NUM_PP] = negv;
    l1     = csa(opnd[0], opnd[1], opnd[2]);
    l2     = csa(opnd[3], opnd[4], l1.sum);
    l3     = csa(l2.sum, l1.carry, l2.carry);
    prod_d = l3.sum + l3.carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      P <= '0;
    end else begin
      P <= prod_d;
    end
  end

endmodule

// File: tb/tb_smult8_core.sv
// Scoreboard bench for smult8_core; expected products queued at drive time, popped per edge.
module tb_smult8_core;

`ifdef INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  IN1 = '0;
  logic [7:0]  IN2 = '0;
  logic [15:0] P;

  int checks = 0;
  int errors = 0;

  // In-flight expected values (LAT-1 entries once reset has been applied).
  logic [15:0] sb [$];

  smult8_core dut (
    .clk(clk),
    .rst(rst),
    .IN1(IN1),
    .IN2(IN2),
    .P  (P)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  // Drive one pair for one edge; returns the value P must hold just after that edge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic r,
                       output logic [15:0] exp);
    @(negedge clk);
    IN1 = a;
    IN2 = b;
    rst = r;
    @(posedge clk);
    if (r) begin
      sb.delete();
      for (int i = 0; i < LAT - 1; i++) sb.push_back(16'h0);
      exp = 16'h0;
    end else begin
      sb.push_back(golden(a, b));
      exp = sb.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive(8'd5, 8'd7, 1'b1, exp);
      checks++;
      if (P !== 16'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %h want 0000", i, P);
      end
    end
    for (int i = 0; i < LAT; i++) begin
      drive(8'd5, 8'd7, 1'b0, exp);
      checks++;
      if (P !== exp) begin
        errors++;
        $display("FAIL reset_release[%0d] got %h want %h", i, P, exp);
      end
    end
    checks++;
    if (P !== 16'd35) begin
      errors++;
      $display("FAIL reset_first_result got %h want 0023", P);
    end
  endtask

  // Fixed vectors with hand-derived products, drained through the scoreboard.
  task automatic test_table(input string name, input logic [7:0] a [],
                            input logic [7:0] b [], input logic [15:0] want []);
    logic [15:0] exp;
    for (int i = 0; i < a.size() + LAT - 1; i++) begin
      if (i < a.size()) drive(a[i], b[i], 1'b0, exp);
      else              drive(8'h00, 8'h00, 1'b0, exp);
      if (i >= LAT - 1) begin
        checks++;
        if (P !== want[i-LAT+1] || P !== exp) begin
          errors++;
          $display("FAIL %s[%0d] got %h want %h", name, i - LAT + 1, P, want[i-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_booth();
    logic [7:0] b [6] = '{8'h55, 8'hAA, 8'h33, 8'hCC, 8'h7F, 8'h80};
    logic [15:0] exp;
    for (int i = 0; i < 6 + LAT - 1; i++) begin
      drive(8'hB3, (i < 6) ? b[i] : 8'h00, 1'b0, exp);
      if (i >= LAT - 1) begin
        checks++;
        if (P !== exp) begin
          errors++;
          $display("FAIL booth[%0d] got %h want %h", i - LAT + 1, P, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 30; i++) begin
      logic r;
      r = (i == 20);
      drive(8'($urandom), 8'($urandom), r, exp);
      checks++;
      if (P !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] rst=%0d got %h want %h", i, r, P, exp);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [15:0] exp;
    for (int i = 0; i < 65536 + LAT - 1; i++) begin
      drive(8'(i >> 8), 8'(i), 1'b0, exp);
      if (i >= LAT - 1) begin
        checks++;
        if (P !== exp) begin
          errors++;
          $display("FAIL exhaustive[%0d] got %h want %h", i - LAT + 1, P, exp);
        end
      end
    end
  endtask

  initial begin
    logic [7:0]  sa [5] = '{8'd3, 8'hFD, 8'd3, 8'hFD, 8'd0};
    logic [7:0]  sbv[5] = '{8'd4, 8'd4, 8'hFC, 8'hFC, 8'h80};
    logic [15:0] sw [5] = '{16'd12, 16'hFFF4, 16'hFFF4, 16'd12, 16'h0};
    logic [7:0]  ea [5] = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'h01};
    logic [7:0]  eb [5] = '{8'h80, 8'h7F, 8'h7F, 8'hFF, 8'h80};
    logic [15:0] ew [5] = '{16'h4000, 16'hC080, 16'd16129, 16'h0001, 16'hFF80};
    test_reset();
    test_table("signs", sa, sbv, sw);
    test_table("extremes", ea, eb, ew);
    test_booth();
    test_back_to_back();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/smult8_core.md
Name: smult8_core

Overview:
- Signed 8x8-bit two's-complement multiplier producing an exact 16-bit signed product.
- Datapath: radix-4 Booth partial-product generation, then a carry-save reduction tree and a final carry-propagate adder.
- Output is registered on one clock with synchronous active-high reset.
- Sits as the arithmetic kernel of the smult8 circuit; the file-driven bench applies one operand pair per sample and logs P.

Parameters:
- WIDTH, 8, operand width in bits (signed); must be even (radix-4 Booth).
- OUTWIDTH, 16, product width; fixed at 2*WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- IN1  input  WIDTH  signed multiplicand (two's complement).
- IN2  input  WIDTH  signed multiplier (two's complement).
- P    output OUTWIDTH  signed product register.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: while rst=1 at a rising clk edge, P <= 0. Any partial computation is discarded. Reset has priority over a simultaneous operand capture.
- Latency: 1 cycle. At each rising clk edge with rst=0, P <= IN1*IN2 as a full signed product.
- No handshake: a new operand pair is accepted every cycle, with throughput 1/cycle.
- Arithmetic is exact; there is no truncation and no rounding.
  - Range is -16256 (-128*127) to +16384 (-128*-128). This fits in 16 bits signed, so there is never overflow.
- Booth encoding:
  - Recode IN2 into WIDTH/2 = 4 digits in {-2,-1,0,+1,+2}, using bit triplets (b[2i+1], b[2i], b[2i-1]) with b[-1]=0.
  - Each partial product is IN1 sign-extended to WIDTH+1 bits, shifted left 1 for |d|=2, and bitwise-inverted with +1 injected at LSB for negative digits.
- Sign handling: sign-extend each partial product to OUTWIDTH bits (the sign-extension-constant trick is also acceptable). The result must be bit-identical to the golden model.
- Reduction: sum the 4 partial products and 4 negate-carries with 3:2 compressors (or equivalent) to two vectors, then a single OUTWIDTH-bit adder. Discard the carry-out beyond OUTWIDTH.
- X-free: P is never X after the first reset cycle, provided the inputs are known.
- Operand changes between edges have no effect on P until the next edge.

Optional Feature:
- Macro INPUT_REG_EN.
- Defined:
  - IN1/IN2 are captured into input registers (reset to 0) before the Booth stage.
  - Latency becomes 2 cycles and throughput stays 1/cycle.
  - rst clears both the input and output registers.
- Undefined: there are no input registers and latency is 1 cycle, as specified above.

Decomposition:
- Shared package smult8_pkg:
  - constants WIDTH=8, OUTWIDTH=16, NUM_PP=WIDTH/2;
  - a typedef for the Booth digit encoding (neg, one, two flags);
  - a typedef for the partial-product vector array.
- One sub-module: booth_pp_gen.
  - Takes the multiplicand plus one 3-bit multiplier triplet.
  - Returns one sign-extended partial product and its negate-carry bit.
  - Instantiated NUM_PP times.

Test Plan:
- Reset: hold rst=1 with IN1=5, IN2=7 for 2 edges -> P=0; release -> P=35 one edge later (two with INPUT_REG_EN).
- Basic signs: (3,4)->12; (-3,4)->-12; (3,-4)->-12; (-3,-4)->12; (0,-128)->0.
- Extremes: (-128,-128)->16384 (0x4000); (-128,127)->-16256 (0xC080); (127,127)->16129; (-1,-1)->1; (1,-128)->-128.
- Booth digit coverage: IN2 in {0x55, 0xAA, 0x33, 0xCC, 0x7F, 0x80} with IN1=-77 -> P equals golden signed product for each.
- Back-to-back throughput: new pair every cycle for 20 cycles -> each P matches its pair's product delayed by exactly the latency.
  - Assert rst mid-stream -> P=0 on the next edge and correct results resume afterward.
- Exhaustive: all 65536 (IN1,IN2) pairs against the golden model IN1*IN2 (16-bit signed), with zero mismatches.
